sodor_rand_instr_gen: RTL and testbench

//  Synthesizable, seeded random RV32I instruction generator driving the core imem response path in

---
 rtl/sodor_rand_instr_gen.sv | 179 +++++++++++++++++
 tb/tb_sodor_rand_instr_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sodor_rand_instr_gen.sv
`default_nettype none
// ============================================================================
// Module   : sodor_rand_instr_gen
// Purpose  : Seeded random RV32I instruction source for the core imem
//            response path. Emits WARMUP NOPs, NUM_INSTR random words
//            (I-type / load / store / R-type / mixed), then DRAIN NOPs over
//            a valid/ready handshake, then reports done.
// Config   : RAND_RD_NONZERO_EN - random non-store words with rd==0 are
//            emitted with rd=1 instead.
// Revision : 1.0 - initial release
// ============================================================================
module sodor_rand_instr_gen #(
  parameter logic [31:0] SEED         = 32'h0000_02DF,
  parameter int unsigned NUM_INSTR    = 100,
  parameter int unsigned WARMUP_NOPS  = 3,
  parameter int unsigned DRAIN_NOPS   = 5,
  parameter logic [11:0] MEM_IMM_MASK = 12'h03C,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_mode,
  output logic             o_instr_valid,
  input  logic             i_instr_ready,
  output logic [31:0]      o_instr_bits,
  output logic [CNT_W-1:0] o_instr_count,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [31:0] c_TAPS     = 32'h8020_0003;
  localparam logic [31:0] c_NOP      = 32'h0000_0013;
  localparam logic [31:0] c_SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_lfsr;
  logic [2:0]       r_mode;
  logic [31:0]      r_warm_left;
  logic [31:0]      r_run_left;
  logic [31:0]      r_drain_left;
  logic [CNT_W-1:0] r_count;
  logic             w_valid;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic [31:0]      w_rand_word;

  // Phases with a zero length are skipped so the next phase starts directly.
  function automatic state_t after_warmup();
    if (NUM_INSTR != 0)       return S_RUN;
    else if (DRAIN_NOPS != 0) return S_DRAIN;
    else                      return S_DONE;
  endfunction

  function automatic state_t after_run();
    return (DRAIN_NOPS != 0) ? S_DRAIN : S_DONE;
  endfunction

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and status outputs; a phase ends on accept of its last word.
  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = (WARMUP_NOPS != 0) ? S_WARMUP : after_warmup();
      end
      S_WARMUP: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        if (i_instr_ready && r_warm_left == 32'd1) w_state_nxt = after_warmup();
      end
      S_RUN: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        if (i_instr_ready && r_run_left == 32'd1) w_state_nxt = after_run();
      end
      S_DRAIN: begin
        w_valid = 1'b1;
        w_busy  = 1'b1;
        if (i_instr_ready && r_drain_left == 32'd1) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = w_valid && i_instr_ready;

  // Phase counters, mode latch, LFSR and accepted-instruction counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_lfsr       <= c_SEED_EFF;
      r_mode       <= 3'd0;
      r_warm_left  <= 32'd0;
      r_run_left   <= 32'd0;
      r_drain_left <= 32'd0;
      r_count      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode       <= (i_mode > 3'd4) ? 3'd0 : i_mode;
            r_warm_left  <= 32'(WARMUP_NOPS);
            r_run_left   <= 32'(NUM_INSTR);
            r_drain_left <= 32'(DRAIN_NOPS);
          end
        end
        S_WARMUP: if (w_accept) r_warm_left <= r_warm_left - 32'd1;
        S_RUN: begin
          if (w_accept) begin
            r_run_left <= r_run_left - 32'd1;
            r_lfsr     <= (r_lfsr >> 1) ^ (r_lfsr[0] ? c_TAPS : 32'd0);
            if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
          end
        end
        S_DRAIN: if (w_accept) r_drain_left <= r_drain_left - 32'd1;
        default: ;
      endcase
    end
  end

  // Combinational decode of the current LFSR state into an instruction word.
  always_comb begin
    logic [11:0] v_imm;
    logic [11:0] v_mimm;
    logic [11:0] v_iimm;
    logic [4:0]  v_rd;
    logic [2:0]  v_f3;
    logic [2:0]  v_st_f3;
    logic [6:0]  v_f7;
    logic [2:0]  v_kind;
    v_imm   = r_lfsr[31:20];
    v_f3    = r_lfsr[14:12];
    v_rd    = r_lfsr[11:7];
`ifdef RAND_RD_NONZERO_EN
    if (v_rd == 5'd0) v_rd = 5'd1;
`endif
    v_mimm  = v_imm & MEM_IMM_MASK;
    v_iimm  = (v_f3 == 3'd5) ? (v_imm & 12'h41F) :
              (v_f3 == 3'd1) ? (v_imm & 12'h01F) : v_imm;
    v_st_f3 = (r_lfsr[13:12] == 2'b11) ? 3'd2 : {1'b0, r_lfsr[13:12]};
    v_f7    = ((v_f3 == 3'd0 || v_f3 == 3'd5) && r_lfsr[30]) ? 7'h20 : 7'h00;
    v_kind  = (r_mode == 3'd4) ? {1'b0, r_lfsr[1:0]} : r_mode;
    case (v_kind)
      3'd1:    w_rand_word = {v_mimm, 5'd0, r_lfsr[14], 2'b00, v_rd, 7'h03};
      3'd2:    w_rand_word = {v_mimm[11:5], r_lfsr[24:20], 5'd0, v_st_f3, v_mimm[4:0], 7'h23};
      3'd3:    w_rand_word = {v_f7, r_lfsr[24:20], r_lfsr[19:15], v_f3, v_rd, 7'h33};
      default: w_rand_word = {v_iimm, r_lfsr[19:15], v_f3, v_rd, 7'h13};
    endcase
  end

  assign o_instr_valid = w_valid;
  assign o_instr_bits  = (r_state == S_RUN) ? w_rand_word : c_NOP;
  assign o_instr_count = r_count;
  assign o_busy        = w_busy;
  assign o_done        = w_done;

endmodule
`default_nettype wire

// File: tb/tb_sodor_rand_instr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sodor_rand_instr_gen
// Purpose  : Randomized-handshake bench for sodor_rand_instr_gen against a
//            reference model of the instruction stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sodor_rand_instr_gen;

  localparam int unsigned c_NUM   = 100;
  localparam int unsigned c_WARM  = 3;
  localparam int unsigned c_DRAIN = 5;
  localparam int          c_TOTAL = c_WARM + c_NUM + c_DRAIN;
  localparam int          c_BUDGET = 3000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_mode = 3'd0;
  logic        i_instr_ready = 1'b0;
  logic        o_instr_valid;
  logic [31:0] o_instr_bits;
  logic [15:0] o_instr_count;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_fail   = 0;

  sodor_rand_instr_gen dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_mode        (i_mode),
    .o_instr_valid (o_instr_valid),
    .i_instr_ready (i_instr_ready),
    .o_instr_bits  (o_instr_bits),
    .o_instr_count (o_instr_count),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Galois LFSR, shift right: feedback taps applied when the bit shifted out is 1.
  function automatic int unsigned lfsr_next(input int unsigned s);
    int unsigned n;
    n = s / 2;
    if (s % 2 == 1) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  // Instruction word for a given LFSR state, built from the field rules.
  function automatic int unsigned model_word(input int unsigned s, input int mode);
    int unsigned imm, rs2, rs1, f3, rd, kind, f7, mimm, sf3;
    imm  = (s >> 20) % 4096;
    rs2  = (s >> 20) % 32;
    rs1  = (s >> 15) % 32;
    f3   = (s >> 12) % 8;
    rd   = (s >> 7) % 32;
`ifdef RAND_RD_NONZERO_EN
    if (rd == 0) rd = 1;
`endif
    kind = (mode > 4) ? 0 : mode;
    if (kind == 4) kind = s % 4;
    mimm = imm & 32'h03C;
    case (kind)
      1: begin
        // LB or LBU chosen by bit 14 of the state.
        return (mimm << 20) | ((((s >> 14) % 2) * 4) << 12) | (rd << 7) | 32'h03;
      end
      2: begin
        sf3 = ((s >> 12) % 4 == 3) ? 2 : (s >> 12) % 4;
        return ((mimm / 32) << 25) | (rs2 << 20) | (sf3 << 12) | ((mimm % 32) << 7) | 32'h23;
      end
      3: begin
        f7 = ((f3 == 0 || f3 == 5) && ((s >> 30) % 2 == 1)) ? 32'h20 : 0;
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      end
      default: begin
        if (f3 == 5) imm = imm & 32'h41F;
        else if (f3 == 1) imm = imm & 32'h01F;
        return (imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      end
    endcase
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    i_reset = 1'b0;
    i_start = 1'b0;
    i_instr_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    i_reset = 1'b1;
  endtask

  // One complete run; optional stall point and optional reset-abort point
  // (both given as indices into the accepted-word sequence, -1 = none).
  task automatic run_mode(input int mode, input int stall_at, input int abort_at);
    int unsigned exp_q[$];
    int unsigned s;
    int          idx;
    int          cyc;
    int          run_before;
    bit          stalled;
    logic [31:0] saved_bits;
    logic [15:0] saved_cnt;

    s = 32'h0000_02DF;
    for (int i = 0; i < int'(c_WARM); i++) exp_q.push_back(32'h13);
    for (int i = 0; i < int'(c_NUM); i++) begin
      exp_q.push_back(model_word(s, mode));
      s = lfsr_next(s);
    end
    for (int i = 0; i < int'(c_DRAIN); i++) exp_q.push_back(32'h13);

    do_reset(2);
    i_mode  = 3'(mode);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;

    idx = 0;
    cyc = 0;
    stalled = 1'b0;
    while (!o_done && cyc < c_BUDGET) begin
      if (stall_at >= 0 && idx == stall_at && !stalled) begin
        stalled    = 1'b1;
        saved_bits = o_instr_bits;
        saved_cnt  = o_instr_count;
        i_instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("stall_bits", o_instr_bits, saved_bits);
        check_eq("stall_count", 32'(o_instr_count), 32'(saved_cnt));
        check_eq("stall_valid", 32'(o_instr_valid), 32'd1);
      end
      i_instr_ready = ($urandom_range(0, 3) != 0);
      // Start pulses and mode changes mid-run must be ignored.
      i_start = ($urandom_range(0, 15) == 0);
      i_mode  = 3'($urandom_range(0, 7));
      check_eq("valid_busy", 32'(o_instr_valid), 32'd1);
      if (o_instr_valid && i_instr_ready) begin
        run_before = idx - int'(c_WARM);
        if (run_before < 0) run_before = 0;
        if (run_before > int'(c_NUM)) run_before = c_NUM;
        if (idx < c_TOTAL) check_eq($sformatf("word[%0d]", idx), o_instr_bits, exp_q[idx]);
        else check_eq("extra_word", 32'(idx), 32'(c_TOTAL - 1));
        check_eq("count_at_accept", 32'(o_instr_count), 32'(run_before));
        idx++;
        if (abort_at >= 0 && idx == abort_at) begin
          @(negedge clk);
          i_start = 1'b0;
          i_reset = 1'b0;
          @(negedge clk);
          i_reset = 1'b1;
          check_eq("abort_valid", 32'(o_instr_valid), 32'd0);
          check_eq("abort_busy", 32'(o_busy), 32'd0);
          check_eq("abort_count", 32'(o_instr_count), 32'd0);
          return;
        end
      end
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0;
    i_instr_ready = 1'b0;
    check_eq("timeout", 32'(cyc < c_BUDGET), 32'd1);
    check_eq("words_accepted", 32'(idx), 32'(c_TOTAL));
    check_eq("final_count", 32'(o_instr_count), 32'(c_NUM));
    check_eq("final_done", 32'(o_done), 32'd1);
    check_eq("final_valid", 32'(o_instr_valid), 32'd0);
    check_eq("final_busy", 32'(o_busy), 32'd0);
    // DONE holds; a start pulse here is ignored.
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("done_hold", 32'(o_done), 32'd1);
    check_eq("done_hold_valid", 32'(o_instr_valid), 32'd0);
  endtask

  initial begin
    // Reset state.
    do_reset(3);
    check_eq("rst_valid", 32'(o_instr_valid), 32'd0);
    check_eq("rst_bits", o_instr_bits, 32'h0000_0013);
    check_eq("rst_count", 32'(o_instr_count), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_done", 32'(o_done), 32'd0);
    // IDLE without start stays idle.
    repeat (3) @(negedge clk);
    check_eq("idle_valid", 32'(o_instr_valid), 32'd0);

    run_mode(0, c_WARM + 50, -1);
    run_mode(1, -1, -1);
    run_mode(2, -1, -1);
    run_mode(3, c_WARM + 10, -1);
    run_mode(4, -1, -1);
    run_mode(4, -1, c_WARM + 40);
    run_mode(4, -1, -1);
    run_mode(6, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
